// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path definitions.
// Holds the CRC-32 constants, the per-frame status record exchanged with
// eth_capture, and the state encoding of the FCS checker.
package eth_pkg;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB_20E3;

  typedef struct packed {
    logic        crc_ok;
    logic        runt;
    logic        giant;
    logic        abort;
    logic [10:0] len;
  } eth_rx_status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PASS
  } eth_rx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Ports:
//   crc_i  - current CRC register value
//   data_i - byte to absorb (LSB first on the wire)
//   crc_o  - CRC register value after absorbing data_i
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i ^ {24'h0, data_i};
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_o[0]) crc_o = {1'b0, crc_o[31:1]} ^ ETH_CRC_POLY;
      else          crc_o = {1'b0, crc_o[31:1]};
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: computes CRC-32 over the post-SFD byte stream, strips
// the trailing 4-byte FCS through a 4-byte delay line and reports per-frame
// status alongside eop.
// Optional feature: define ETH_FCS_STATS_EN to build the good/bad frame
// counters; otherwise stat_good/stat_bad are tied to 0.
// Ports:
//   clk50, reset                      - clock, async active-high reset
//   rxdata/rxvalid/rxsop/rxeop        - input byte stream from eth_rmii_rx
//   data/valid/sop/eop                - forwarded stream, FCS removed
//   crc_ok/err_runt/err_giant/err_abort/len - frame status, held from eop
//   stat_good/stat_bad                - 16-bit wrapping frame counters
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  input  logic        rxsop,
  input  logic        rxeop,
  output logic [7:0]  data,
  output logic        valid,
  output logic        sop,
  output logic        eop,
  output logic        crc_ok,
  output logic        err_runt,
  output logic        err_giant,
  output logic        err_abort,
  output logic [10:0] len,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
);

  localparam logic [11:0] MIN_LEN_C = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_C = 12'(MAX_LEN);
  localparam logic [11:0] CNT_SAT   = 12'd2047;

  eth_rx_state_t     state_q, state_d;
  logic [31:0]       crc_q, crc_d, crc_in, crc_next;
  logic [11:0]       count_q, count_d;
  logic [3:0][7:0]   hold_q, hold_d;   // [0] newest, [3] oldest
  logic              first_q, first_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  eth_rx_status_t    status_q, status_d;

  logic in_frame, start, close;

  assign in_frame = (state_q != ST_IDLE);
  assign start    = rxvalid && rxsop;
  // A new rxsop inside a frame closes the old one as an abort unless the
  // same cycle also carries rxeop, in which case the close is a normal end.
  assign close    = in_frame && (rxeop || start);
  assign crc_in   = start ? ETH_CRC_INIT : crc_q;

  eth_crc32_byte u_crc (
    .crc_i  (crc_in),
    .data_i (rxdata),
    .crc_o  (crc_next)
  );

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    count_d  = count_q;
    hold_d   = hold_q;
    first_d  = first_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    status_d = status_q;

    if (close) begin
      eop_d           = 1'b1;
      status_d.abort  = !rxeop;
      status_d.crc_ok = (crc_q == ETH_CRC_RESIDUE) && rxeop;
      status_d.runt   = (count_q < MIN_LEN_C);
      status_d.giant  = (count_q > MAX_LEN_C);
      status_d.len    = (count_q >= 12'd4) ? 11'(count_q - 12'd4) : '0;
      state_d         = ST_IDLE;
    end

    if (start) begin
      state_d = ST_FILL;
      crc_d   = crc_next;
      count_d = 12'd1;
      hold_d  = {24'h0, rxdata};
      first_d = 1'b1;
    end else if (in_frame && rxvalid && !rxeop) begin
      crc_d   = crc_next;
      count_d = (count_q >= CNT_SAT) ? count_q : count_q + 12'd1;
      hold_d  = {hold_q[2:0], rxdata};
      if (state_q == ST_PASS) begin
        data_d  = hold_q[3];
        valid_d = 1'b1;
        sop_d   = first_q;
        first_d = 1'b0;
      end else if (count_q == 12'd3) begin
        state_d = ST_PASS;
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      crc_q    <= ETH_CRC_INIT;
      count_q  <= '0;
      hold_q   <= '0;
      first_q  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      first_q  <= first_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      status_q <= status_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign crc_ok    = status_q.crc_ok;
  assign err_runt  = status_q.runt;
  assign err_giant = status_q.giant;
  assign err_abort = status_q.abort;
  assign len       = status_q.len;

`ifdef ETH_FCS_STATS_EN
  logic [15:0] stat_good_q, stat_good_d;
  logic [15:0] stat_bad_q, stat_bad_d;

  always_comb begin
    stat_good_d = stat_good_q;
    stat_bad_d  = stat_bad_q;
    if (eop_d) begin
      if (status_d.crc_ok && !status_d.runt && !status_d.giant)
        stat_good_d = stat_good_q + 16'd1;
      else
        stat_bad_d  = stat_bad_q + 16'd1;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_bad_q  <= stat_bad_d;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_bad  = stat_bad_q;
`else
  assign stat_good = '0;
  assign stat_bad  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
module tb_eth_rx_fcs_check;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rxdata = '0;
  logic        rxvalid = 1'b0;
  logic        rxsop = 1'b0;
  logic        rxeop = 1'b0;
  logic [7:0]  data;
  logic        valid, sop, eop, crc_ok, err_runt, err_giant, err_abort;
  logic [10:0] len;
  logic [15:0] stat_good, stat_bad;

  always #10 clk50 = ~clk50;

  eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk50     (clk50),
    .reset     (reset),
    .rxdata    (rxdata),
    .rxvalid   (rxvalid),
    .rxsop     (rxsop),
    .rxeop     (rxeop),
    .data      (data),
    .valid     (valid),
    .sop       (sop),
    .eop       (eop),
    .crc_ok    (crc_ok),
    .err_runt  (err_runt),
    .err_giant (err_giant),
    .err_abort (err_abort),
    .len       (len),
    .stat_good (stat_good),
    .stat_bad  (stat_bad)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_good = 0;
  int exp_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC-32 (reflected, poly 0xEDB88320).
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  typedef struct {
    int          nbytes;
    int          sop_err;
    int          data_err;
    logic        ok, runt, giant, abort;
    logic [10:0] ln;
  } rec_t;

  rec_t        eop_q[$];
  logic [7:0]  exp_data[$];
  int          cur_n = 0;
  int          sop_err = 0;
  int          data_err = 0;
  int          collide = 0;
  int          total_valid = 0;

  always @(negedge clk50) begin
    rec_t r;
    logic [7:0] e;
    if (reset) begin
      cur_n = 0;
    end else begin
      if (valid) begin
        total_valid++;
        if (eop) collide++;
        if ((cur_n == 0) != (sop === 1'b1)) sop_err++;
        if (exp_data.size() == 0) data_err++;
        else begin
          e = exp_data.pop_front();
          if (e !== data) data_err++;
        end
        cur_n++;
      end
      if (eop) begin
        r.nbytes = cur_n; r.sop_err = sop_err; r.data_err = data_err;
        r.ok = crc_ok; r.runt = err_runt; r.giant = err_giant; r.abort = err_abort;
        r.ln = len;
        eop_q.push_back(r);
        cur_n = 0; sop_err = 0; data_err = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] fbuf[2048];
  logic       pend_eop = 1'b0;

  task automatic build_frame(input int n, input int flip, input int seed);
    logic [31:0] c;
    int p;
    p = (n >= 4) ? n - 4 : n;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < p; i++) begin
      fbuf[i] = 8'((i * 13 + seed * 29 + 1) & 255);
      c = crc_upd(c, fbuf[i]);
    end
    if (n >= 4) begin
      c = ~c;
      for (int k = 0; k < 4; k++) fbuf[p + k] = c[8*k +: 8];
    end
    if (flip >= 0) fbuf[flip] = fbuf[flip] ^ 8'h01;
  endtask

  task automatic drive(input logic [7:0] b, input logic s);
    rxdata = b; rxvalid = 1'b1; rxsop = s;
    if (s && pend_eop) begin rxeop = 1'b1; pend_eop = 1'b0; end
    @(posedge clk50); #1;
    rxvalid = 1'b0; rxsop = 1'b0; rxeop = 1'b0;
  endtask

  // Sends nsend of the n built bytes; a complete frame ends with rxeop,
  // either on its own cycle or merged with the next frame's rxsop.
  task automatic send_frame(input int n, input int nsend, input bit merge);
    for (int i = 0; i < nsend - 4; i++) exp_data.push_back(fbuf[i]);
    for (int i = 0; i < nsend; i++) drive(fbuf[i], i == 0);
    if (nsend == n) begin
      if (merge) pend_eop = 1'b1;
      else begin
        rxeop = 1'b1; @(posedge clk50); #1; rxeop = 1'b0;
      end
    end
  endtask

  task automatic expect_eop(input string name, input int nb, input int ln,
                            input bit ok, input bit runt, input bit giant, input bit abort);
    rec_t r;
    int k;
    k = 0;
    while (eop_q.size() == 0 && k < 50) begin @(negedge clk50); #1; k++; end
    if (eop_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_eop_timeout: got no eop expected eop within 50 cycles", name);
      return;
    end
    r = eop_q.pop_front();
    chk({name, "_nbytes"}, r.nbytes, nb);
    chk({name, "_len"}, {21'h0, r.ln}, ln);
    chk({name, "_flags"}, {28'h0, r.ok, r.runt, r.giant, r.abort}, {28'h0, ok, runt, giant, abort});
    chk({name, "_sop_err"}, r.sop_err, 0);
    chk({name, "_data_err"}, r.data_err, 0);
    if (ok && !runt && !giant) exp_good++; else exp_bad++;
  endtask

  task automatic check_stats(input string name);
`ifdef ETH_FCS_STATS_EN
    chk({name, "_stat_good"}, {16'h0, stat_good}, exp_good & 16'hFFFF);
    chk({name, "_stat_bad"},  {16'h0, stat_bad},  exp_bad & 16'hFFFF);
`else
    chk({name, "_stat_good"}, {16'h0, stat_good}, 0);
    chk({name, "_stat_bad"},  {16'h0, stat_bad},  0);
`endif
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_outs"},
        {5'h0, data, valid, sop, eop, crc_ok, err_runt, err_giant, err_abort, len}, 0);
    chk({name, "_stats"}, {stat_good, stat_bad}, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int total;
    int flip;
    int exp_len;
    bit ok;
    bit runt;
    bit giant;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] c;
    logic [7:0]  kat;
    int          tv;

    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      kat = 8'h31 + 8'(i);
      c = crc_upd(c, kat);
    end
    if (~c != 32'hCBF4_3926) begin
      $display("FAIL model_crc: got 0x%0h expected 0xcbf43926", ~c);
      $fatal(1);
    end

    vecs[0]  = '{277, -1, 273, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{277, -1, 273, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{277, -1, 273, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{277, -1, 273, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{277, -1, 273, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{277, 100, 273, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{60,   -1, 56,   1'b1, 1'b1, 1'b0};
    vecs[7]  = '{63,   -1, 59,   1'b1, 1'b1, 1'b0};
    vecs[8]  = '{64,   -1, 60,   1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1518, -1, 1514, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1519, -1, 1515, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1522, -1, 1518, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk50);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk50);
    #1;

    // Idle noise: bytes without rxsop and a stray rxeop are ignored.
    tv = total_valid;
    for (int i = 0; i < 5; i++) drive(8'hA0 + 8'(i), 1'b0);
    rxeop = 1'b1; @(posedge clk50); #1; rxeop = 1'b0;
    repeat (5) @(posedge clk50);
    #1;
    chk("idle_valid", total_valid - tv, 0);
    chk("idle_eop", eop_q.size(), 0);

    for (int v = 0; v < 12; v++) begin
      build_frame(vecs[v].total, vecs[v].flip, v);
      send_frame(vecs[v].total, vecs[v].total, 1'b0);
      expect_eop($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].exp_len,
                 vecs[v].ok, vecs[v].runt, vecs[v].giant, 1'b0);
      repeat (2) @(posedge clk50);
      #1;
    end
    check_stats("table");

    // Abort: rxsop after 30 bytes, then a full 64-byte frame.
    build_frame(64, -1, 20);
    send_frame(64, 30, 1'b0);
    build_frame(64, -1, 21);
    send_frame(64, 64, 1'b0);
    expect_eop("abort_a", 26, 26, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_eop("abort_b", 60, 60, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stats("abort");

    // rxeop merged with the next frame's rxsop.
    build_frame(70, -1, 30);
    send_frame(70, 70, 1'b1);
    build_frame(80, -1, 31);
    send_frame(80, 80, 1'b0);
    expect_eop("merge_a", 66, 66, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_eop("merge_b", 76, 76, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stats("merge");

    // 3-byte frame: nothing forwarded, runt with len 0.
    build_frame(3, -1, 40);
    send_frame(3, 3, 1'b0);
    expect_eop("short3", 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset at byte 50 of a frame: outputs clear at once, no eop follows.
    build_frame(100, -1, 50);
    send_frame(100, 50, 1'b0);
    @(negedge clk50);
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    chk("midreset_fwd_left", exp_data.size(), 0);
    exp_data.delete();
    exp_good = 0; exp_bad = 0;
    repeat (3) @(posedge clk50);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk50);
    #1;
    chk("midreset_no_eop", eop_q.size(), 0);
    build_frame(100, -1, 51);
    send_frame(100, 100, 1'b0);
    expect_eop("after_reset", 96, 96, 1'b1, 1'b0, 1'b0, 1'b0);
    check_stats("after_reset");

    chk("eop_valid_collide", collide, 0);
    chk("exp_data_drained", exp_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
